// File: rtl/picorv32_regs_ctrl_pkg.sv
// Shared types for the PicoRV32 register-file write-port sequencer.
package picorv32_regs_pkg;

    typedef logic [5:0]  regaddr_t;
    typedef logic [31:0] regdata_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        HOLD_RD
    } ctrl_state_t;

    localparam regaddr_t X0 = 6'd0;

endpackage

// File: rtl/picorv32_regs_ctrl_if.sv
// Bundle of CPU writeback, debug requester and register-file signals around the controller.
interface picorv32_regs_ctrl_if;
    import picorv32_regs_pkg::*;

    logic        busy;
    logic        cpu_wen;
    regaddr_t    cpu_waddr;
    regdata_t    cpu_wdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    regdata_t    dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    regdata_t    dbg_rdata;
    logic        rf_wen;
    regaddr_t    rf_waddr;
    regdata_t    rf_wdata;
    regaddr_t    rf_raddr;
    regdata_t    rf_rdata;

    // Controller side.
    modport slave (
        input  cpu_wen, cpu_waddr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  rf_rdata,
        output busy, dbg_gnt, dbg_rvalid, dbg_rdata,
        output rf_wen, rf_waddr, rf_wdata, rf_raddr
    );

    // Core, debug unit and register file side.
    modport master (
        output cpu_wen, cpu_waddr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output rf_rdata,
        input  busy, dbg_gnt, dbg_rvalid, dbg_rdata,
        input  rf_wen, rf_waddr, rf_wdata, rf_raddr
    );

endinterface

// File: rtl/picorv32_regs_arb.sv
// Fixed-priority write-port arbiter (CPU over debug) with one-cycle grant spacing.
module picorv32_regs_arb
    import picorv32_regs_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     cpu_wen,
    input  regaddr_t cpu_waddr,
    input  logic     dbg_req,
    input  logic     dbg_we,
    output logic     cpu_fwd,
    output logic     dbg_wr_gnt,
    output logic     dbg_rd_gnt
);

    logic gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= 1'b0;
        end else begin
            gnt_q <= dbg_wr_gnt | dbg_rd_gnt;
        end
    end

    // Writes to x0 never reach the file, so they do not block a debug write either.
    always_comb begin
        cpu_fwd    = cpu_wen && (cpu_waddr[4:0] != 5'd0);
        dbg_wr_gnt = en && !gnt_q && dbg_req && dbg_we && !cpu_fwd;
        dbg_rd_gnt = en && !gnt_q && dbg_req && !dbg_we;
    end

endmodule

// File: rtl/picorv32_regs_ctrl.sv
// Register-file write-port sequencer: post-reset scrub, then CPU/debug sharing of the write port.
// Scrub is built only when PICORV32_REGS_CLEAR_EN is defined; otherwise reset enters RUN directly.
module picorv32_regs_ctrl
    import picorv32_regs_pkg::*;
#(
    parameter int unsigned NREGS   = 31,
    parameter regdata_t    CLR_VAL = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    picorv32_regs_ctrl_if.slave   bus
);

    ctrl_state_t state_q, state_d;
    logic        rvalid_q;
    regdata_t    rdata_q;

    logic        arb_en;
    logic        cpu_fwd;
    logic        dbg_wr_gnt;
    logic        dbg_rd_gnt;

    logic        busy;
    logic        rf_wen;
    regaddr_t    rf_waddr;
    regdata_t    rf_wdata;
    regaddr_t    rf_raddr;

`ifdef PICORV32_REGS_CLEAR_EN
    regaddr_t    clr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q <= regaddr_t'(1);
        end else if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + regaddr_t'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef PICORV32_REGS_CLEAR_EN
            state_q <= CLEAR;
`else
            state_q <= RUN;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
`ifdef PICORV32_REGS_CLEAR_EN
            CLEAR:   if (clr_cnt_q == regaddr_t'(NREGS)) state_d = RUN;
`endif
            RUN:     if (dbg_rd_gnt) state_d = HOLD_RD;
            HOLD_RD: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign arb_en = !rst && (state_q == RUN);

    picorv32_regs_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (arb_en),
        .cpu_wen    (bus.cpu_wen),
        .cpu_waddr  (bus.cpu_waddr),
        .dbg_req    (bus.dbg_req),
        .dbg_we     (bus.dbg_we),
        .cpu_fwd    (cpu_fwd),
        .dbg_wr_gnt (dbg_wr_gnt),
        .dbg_rd_gnt (dbg_rd_gnt)
    );

    // Outputs are forced idle while rst is high so nothing is written during reset.
    always_comb begin
        busy     = 1'b0;
        rf_wen   = 1'b0;
        rf_waddr = X0;
        rf_wdata = '0;
        rf_raddr = X0;
`ifdef PICORV32_REGS_CLEAR_EN
        busy     = rst || (state_q == CLEAR);
`endif
        if (!rst) begin
            unique case (state_q)
`ifdef PICORV32_REGS_CLEAR_EN
                CLEAR: begin
                    rf_wen   = 1'b1;
                    rf_waddr = clr_cnt_q;
                    rf_wdata = CLR_VAL;
                end
`endif
                RUN, HOLD_RD: begin
                    if (cpu_fwd) begin
                        rf_wen   = 1'b1;
                        rf_waddr = bus.cpu_waddr;
                        rf_wdata = bus.cpu_wdata;
                    end else if (dbg_wr_gnt) begin
                        rf_wen   = (bus.dbg_addr != 5'd0);
                        rf_waddr = {1'b0, bus.dbg_addr};
                        rf_wdata = bus.dbg_wdata;
                    end
                    if (dbg_rd_gnt) begin
                        rf_raddr = {1'b0, bus.dbg_addr};
                    end
                end
                default: ;
            endcase
        end
    end

    // x0 reads are answered locally; the file's x0 location is never trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= dbg_rd_gnt;
            if (dbg_rd_gnt) begin
                rdata_q <= (bus.dbg_addr == 5'd0) ? '0 : bus.rf_rdata;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.dbg_gnt    = dbg_wr_gnt | dbg_rd_gnt;
    assign bus.dbg_rvalid = rvalid_q;
    assign bus.dbg_rdata  = rdata_q;
    assign bus.rf_wen     = rf_wen;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.rf_raddr   = rf_raddr;

endmodule

// File: tb/tb_picorv32_regs_ctrl.sv
// Directed bench for picorv32_regs_ctrl with a behavioural register file behind the ports.
module tb_picorv32_regs_ctrl;
    import picorv32_regs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    regdata_t mem [64];

    always #5 clk = ~clk;

    picorv32_regs_ctrl_if bus ();

    picorv32_regs_ctrl #(
        .NREGS   (31),
        .CLR_VAL (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) if (bus.rf_wen) mem[bus.rf_waddr] <= bus.rf_wdata;
    assign bus.rf_rdata = mem[bus.rf_raddr];

    task automatic idle_inputs();
        bus.cpu_wen   = 1'b0;
        bus.cpu_waddr = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

`ifdef PICORV32_REGS_CLEAR_EN
    task automatic test_reset();
        int bad;
        @(negedge clk); rst = 1'b1; idle_inputs();
        #1;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.rf_wen !== 1'b0 || bus.dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: busy=%b wen=%b gnt=%b want 1 0 0",
                     bus.busy, bus.rf_wen, bus.dbg_gnt);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0 || bus.rf_raddr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_regs: rvalid=%b rdata=%h raddr=%0d want 0 0 0",
                     bus.dbg_rvalid, bus.dbg_rdata, bus.rf_raddr);
        end
        // Requests during the scrub must be ignored.
        @(negedge clk); rst = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd5;
        bus.cpu_wen = 1'b1; bus.cpu_waddr = 6'd3; bus.cpu_wdata = 32'h77;
        for (int i = 1; i <= 31; i++) begin
            #1;
            n_tests++;
            if (bus.busy !== 1'b1 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== regaddr_t'(i) ||
                bus.rf_wdata !== 32'h0 || bus.dbg_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL scrub[%0d]: busy=%b wen=%b waddr=%0d wdata=%h gnt=%b want 1 1 %0d 0 0",
                         i, bus.busy, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.dbg_gnt, i);
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL scrub_end: busy=%b wen=%b want 0 0", bus.busy, bus.rf_wen);
        end
        bad = 0;
        for (int i = 1; i <= 31; i++) if (mem[i] !== 32'h0) bad++;
        n_tests++;
        if (bad != 0 || mem[0] !== 32'hDEAD_0000) begin
            n_fail++;
            $display("FAIL scrub_mem: nonzero=%0d x0=%h want 0 dead0000", bad, mem[0]);
        end
    endtask

    task automatic test_reset_mid_scrub();
        int bad;
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk); rst = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        n_tests++;
        if (bus.rf_waddr !== 6'd10 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_scrub_pre: waddr=%0d busy=%b want 10 1", bus.rf_waddr, bus.busy);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.rf_wen !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_scrub_rst: wen=%b busy=%b want 0 1", bus.rf_wen, bus.busy);
        end
        @(negedge clk); rst = 1'b0;
        bad = 0;
        for (int i = 1; i <= 31; i++) begin
            #1;
            if (bus.busy !== 1'b1 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== regaddr_t'(i)) bad++;
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (bad != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_scrub_restart: bad_cycles=%0d busy=%b want 0 0", bad, bus.busy);
        end
    endtask
`else
    task automatic test_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rf_wen !== 1'b0 || bus.dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: busy=%b wen=%b gnt=%b want 0 0 0",
                     bus.busy, bus.rf_wen, bus.dbg_gnt);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0 || bus.rf_raddr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_regs: rvalid=%b rdata=%h raddr=%0d want 0 0 0",
                     bus.dbg_rvalid, bus.dbg_rdata, bus.rf_raddr);
        end
        @(negedge clk); rst = 1'b0;
        bus.cpu_wen = 1'b1; bus.cpu_waddr = 6'd2; bus.cpu_wdata = 32'h0000_0102;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== 6'd2) begin
            n_fail++;
            $display("FAIL first_cycle_write: busy=%b wen=%b waddr=%0d want 0 1 2",
                     bus.busy, bus.rf_wen, bus.rf_waddr);
        end
        @(negedge clk); idle_inputs();
    endtask
`endif

    task automatic test_cpu_write();
        @(negedge clk);
        bus.cpu_wen = 1'b1; bus.cpu_waddr = 6'd5; bus.cpu_wdata = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 6'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL cpu_wr_x5: wen=%b waddr=%0d wdata=%h want 1 5 deadbeef",
                     bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
        end
        @(negedge clk); bus.cpu_waddr = 6'd0; bus.cpu_wdata = 32'h1111_1111;
        #1;
        n_tests++;
        if (bus.rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_wr_x0: wen=%b want 0", bus.rf_wen);
        end
        @(negedge clk); bus.cpu_waddr = 6'h25; bus.cpu_wdata = 32'h5A5A_5A5A;
        #1;
        n_tests++;
        if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 6'h25 || bus.rf_wdata !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL cpu_wr_bit5: wen=%b waddr=%h wdata=%h want 1 25 5a5a5a5a",
                     bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
        end
        @(negedge clk); idle_inputs();
        #1;
        n_tests++;
        if (mem[5] !== 32'hDEAD_BEEF || mem[0] !== 32'hDEAD_0000) begin
            n_fail++;
            $display("FAIL cpu_wr_mem: x5=%h x0=%h want deadbeef dead0000", mem[5], mem[0]);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_wdata = 32'h1234_5678;
        bus.cpu_wen = 1'b1; bus.cpu_waddr = 6'd7; bus.cpu_wdata = 32'hAAAA_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus.dbg_gnt !== 1'b0 || bus.rf_wdata !== 32'hAAAA_0000) begin
                n_fail++;
                $display("FAIL collide[%0d]: gnt=%b wdata=%h want 0 aaaa0000",
                         i, bus.dbg_gnt, bus.rf_wdata);
            end
            @(negedge clk);
        end
        bus.cpu_wen = 1'b0;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== 6'd7 ||
            bus.rf_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL collide_gnt: gnt=%b wen=%b waddr=%0d wdata=%h want 1 1 7 12345678",
                     bus.dbg_gnt, bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
        end
        @(negedge clk); idle_inputs();
        #1;
        n_tests++;
        if (mem[7] !== 32'h1234_5678 || bus.dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_final: x7=%h gnt=%b want 12345678 0", mem[7], bus.dbg_gnt);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd3; bus.dbg_wdata = 32'h33;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: gnt=%b want 1", bus.dbg_gnt);
        end
        @(negedge clk); bus.dbg_addr = 5'd4; bus.dbg_wdata = 32'h44;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b0 || bus.rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: gnt=%b wen=%b want 0 0", bus.dbg_gnt, bus.rf_wen);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1 || bus.rf_waddr !== 6'd4) begin
            n_fail++;
            $display("FAIL b2b_second: gnt=%b waddr=%0d want 1 4", bus.dbg_gnt, bus.rf_waddr);
        end
        @(negedge clk); idle_inputs();
        #1;
        n_tests++;
        if (mem[3] !== 32'h33 || mem[4] !== 32'h44) begin
            n_fail++;
            $display("FAIL b2b_mem: x3=%h x4=%h want 33 44", mem[3], mem[4]);
        end
    endtask

    task automatic test_debug_read();
        @(negedge clk);
        bus.cpu_wen = 1'b1; bus.cpu_waddr = 6'd9; bus.cpu_wdata = 32'hCAFE_0009;
        @(negedge clk);
        bus.cpu_waddr = 6'd11; bus.cpu_wdata = 32'h0000_000B;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 5'd9;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1 || bus.rf_raddr !== 6'd9 || bus.rf_wen !== 1'b1 ||
            bus.rf_waddr !== 6'd11) begin
            n_fail++;
            $display("FAIL rd_gnt: gnt=%b raddr=%0d wen=%b waddr=%0d want 1 9 1 11",
                     bus.dbg_gnt, bus.rf_raddr, bus.rf_wen, bus.rf_waddr);
        end
        @(negedge clk); bus.cpu_wen = 1'b0;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b0 || bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hCAFE_0009) begin
            n_fail++;
            $display("FAIL rd_data: gnt=%b rvalid=%b rdata=%h want 0 1 cafe0009",
                     bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_rdata);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1 || bus.dbg_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_regrant: gnt=%b rvalid=%b want 1 0", bus.dbg_gnt, bus.dbg_rvalid);
        end
        @(negedge clk); bus.dbg_req = 1'b0;
        #1;
        n_tests++;
        if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hCAFE_0009 || bus.dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_second: rvalid=%b rdata=%h gnt=%b want 1 cafe0009 0",
                     bus.dbg_rvalid, bus.dbg_rdata, bus.dbg_gnt);
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_x0_access();
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 5'd0;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_rd_gnt: gnt=%b want 1", bus.dbg_gnt);
        end
        @(negedge clk); bus.dbg_req = 1'b0;
        #1;
        n_tests++;
        if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_rd_data: rvalid=%b rdata=%h want 1 0", bus.dbg_rvalid, bus.dbg_rdata);
        end
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_wdata = 32'hFFFF_FFFF;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1 || bus.rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_wr: gnt=%b wen=%b want 1 0", bus.dbg_gnt, bus.rf_wen);
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        bit done;
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 5'd9;
        #1;
        n_tests++;
        if (bus.dbg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_op_gnt: gnt=%b want 1", bus.dbg_gnt);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; idle_inputs();
        #1;
        n_tests++;
        if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_op_rvalid: rvalid=%b rdata=%h want 0 0", bus.dbg_rvalid, bus.dbg_rdata);
        end
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus.busy === 1'b0) done = 1'b1;
            else @(negedge clk);
            #1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL rst_op_busy_timeout: busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        idle_inputs();
        test_reset();
`ifdef PICORV32_REGS_CLEAR_EN
        test_reset_mid_scrub();
`endif
        test_cpu_write();
        test_collision();
        test_back_to_back();
        test_debug_read();
        test_x0_access();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/picorv32_regs_ctrl.md
Name: picorv32_regs_ctrl

Overview:
Write-port sequencer and arbiter placed in front of the PicoRV32 register file (31 x 32-bit, x1..x31, no reset on the storage).
- After reset it scrubs every register to zero.
- It then shares the single write port and one read address between the CPU writeback path (fixed priority) and a debug requester using a req/gnt handshake.
- Sits between the picorv32 core and picorv32_regs inside the CPU wrapper.

Parameters:
NREGS, 31, number of implemented registers (x1..xNREGS); legal range 15 or 31
CLR_VAL, 32'h0000_0000, value written to each register during scrub

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
busy  out  1  scrub in progress; CPU must be held in reset while high
cpu_wen  in  1  CPU writeback strobe
cpu_waddr  in  6  CPU write address (logical register number)
cpu_wdata  in  32  CPU write data
dbg_req  in  1  debug access request; held until granted
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  5  debug register number
dbg_wdata  in  32  debug write data
dbg_gnt  out  1  one-cycle grant; access is performed in this cycle
dbg_rvalid  out  1  read data valid, one cycle after the read grant
dbg_rdata  out  32  registered read data
rf_wen  out  1  register file write enable
rf_waddr  out  6  register file write address
rf_wdata  out  32  register file write data
rf_raddr  out  6  debug read address to the register file second read port mux
rf_rdata  in  32  combinational register file read data for rf_raddr

Behaviour:
- FSM has three states: CLEAR, RUN, HOLD_RD.
- Reset values: state=CLEAR, clear counter=1, busy=1, dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0, rf_wen=0, rf_waddr=0, rf_wdata=0, rf_raddr=0. Without REGS_CLEAR_EN, state=RUN and busy=0.
- CLEAR:
  - Each cycle: rf_wen=1, rf_waddr=counter, rf_wdata=CLEAR_VAL; counter increments.
  - After the write to address NREGS: go to RUN, busy drops the next cycle.
  - Scrub lasts exactly NREGS cycles after rst deasserts.
  - cpu_wen and dbg_req are ignored; dbg_gnt=0.
- RUN, CPU priority:
  - If cpu_wen=1 and cpu_waddr[4:0]!=0: forward the write combinationally, same cycle, to rf_*.
  - Writes to x0 are suppressed (rf_wen=0). cpu_waddr[5] is passed through unchanged.
- RUN, debug write:
  - When dbg_req=1, dbg_we=1 and the CPU is not writing: dbg_gnt=1 and the write is performed that cycle.
  - dbg_addr=0 is granted but no write occurs.
- RUN, debug read:
  - When dbg_req=1 and dbg_we=0: grant regardless of cpu_wen; rf_raddr={1'b0,dbg_addr}.
  - rf_rdata is captured into dbg_rdata at the clock edge; dbg_rvalid=1 in the next cycle.
  - The next cycle is HOLD_RD: no new grant, then return to RUN.
- Simultaneous CPU and debug write to the same register: CPU wins; debug stays pending and is granted on the next CPU-idle cycle.
- Starvation is accepted. A CPU that writes every cycle blocks debug writes indefinitely; this is documented, not an error.
- Read of x0 returns 0 without relying on the register file.
- Grant is never asserted in two consecutive cycles.
- rst mid-scrub or mid-operation restarts CLEAR from counter=1; any pending debug access is dropped and dbg_rvalid clears.

Optional Feature:
PICORV32_REGS_CLEAR_EN
- Defined: the CLEAR scrub runs after every reset, as described above.
- Undefined: the counter and CLEAR logic are removed; reset enters RUN directly; busy is tied to 0. Register contents after power-up are undefined, which is acceptable for FPGA BRAM initialised to zero.

Decomposition:
- Shared package picorv32_regs_pkg:
  - typedef regaddr_t (logic [5:0]) and regdata_t (logic [31:0])
  - enum ctrl_state_t {CLEAR, RUN, HOLD_RD}
  - localparam X0 = 6'd0
- Optional sub-module picorv32_regs_arb: the two-requester fixed-priority write arbiter (CPU > debug), combinational grant plus one-cycle grant suppression.
- The FSM and counter stay in the top module.

Test Plan:
- Reset scrub: rst for 2 cycles, release → 31 consecutive writes of 0 to addresses 1..31, busy=1 for 31 cycles then 0, with no write to address 0.
- Reset mid-scrub: assert rst at clear counter=10 → counter restarts at 1 and a full 31-cycle scrub follows.
- CPU write: cpu_wen=1, cpu_waddr=5, cpu_wdata=32'hDEAD_BEEF → rf_wen=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF in the same cycle. Repeat with waddr=0 → rf_wen=0.
- Write collision: dbg write x7=32'h1234_5678 while cpu_wen=1 to x7=32'hAAAA_0000 for 3 cycles → dbg_gnt=0 for 3 cycles, then granted in cycle 4. Final x7=32'h1234_5678.
- Debug read: x9 holds 32'hCAFE_0009; dbg read x9 → dbg_gnt=1 in cycle N, dbg_rvalid=1 with dbg_rdata=32'hCAFE_0009 in N+1, no grant in N+1.
- Macro off: build without PICORV32_REGS_CLEAR_EN, release rst → busy=0 and a CPU write is accepted in the first cycle.
